// File: rtl/sat_pkg.sv
// Shared defaults and helpers for the shared saturating-adder arbiter.
package sat_pkg;
  localparam int N_DEF    = 8;
  localparam int NREQ_DEF = 4;

  // Largest positive two's-complement value of width n: {0,1...1}
  function automatic logic [31:0] sat_max(input int n);
    return (32'h1 << (n - 1)) - 32'h1;
  endfunction

  // Most negative two's-complement value of width n: {1,0...0}
  function automatic logic [31:0] sat_min(input int n);
    return 32'h1 << (n - 1);
  endfunction

  function automatic int id_width(input int nreq);
    return (nreq <= 1) ? 1 : $clog2(nreq);
  endfunction
endpackage

// File: rtl/sat_add.sv
// Combinational signed adder that clamps to the representable range on overflow.
module sat_add
  import sat_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] sum,
  output logic                sat
);
  logic [N:0] w_raw;
  logic       w_ovf;

  assign w_raw = {a[N-1], a} + {b[N-1], b};
  // Sign-extended sum disagrees in its top two bits only when the operands overflowed.
  assign w_ovf = w_raw[N] != w_raw[N-1];
  assign sat   = w_ovf;

  always_comb begin
    sum = w_raw[N-1:0];
    if (w_ovf) sum = w_raw[N] ? N'(sat_min(N)) : N'(sat_max(N));
  end
endmodule

// File: rtl/sat_add_arb.sv
// Round-robin arbiter feeding one shared saturating adder; two-stage pipeline.
module sat_add_arb
  import sat_pkg::*;
#(
  parameter int  N    = N_DEF,
  parameter int  NREQ = NREQ_DEF,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*N-1:0]      in1_flat,
  input  logic [NREQ*N-1:0]      in2_flat,
  output logic [NREQ-1:0]        gnt,
  output logic signed [N-1:0]    out,
  output logic                   out_valid,
  output logic [IDW-1:0]         out_id,
  output logic                   out_sat
);
  logic [IDW-1:0]      r_ptr;
  logic [IDW-1:0]      w_win;
  logic [IDW-1:0]      w_ptr_nxt;
  logic                w_any;
  logic                r_s1_valid;
  logic signed [N-1:0] r_s1_a;
  logic signed [N-1:0] r_s1_b;
  logic [IDW-1:0]      r_s1_id;
  logic signed [N-1:0] w_sum;
  logic                w_sat;
  logic signed [N-1:0] r_out;
  logic                r_out_valid;
  logic [IDW-1:0]      r_out_id;
  logic                r_out_sat;

  // ptr is always < NREQ, so one conditional subtract is enough to wrap.
  function automatic int wrap(input int v);
    return (v >= NREQ) ? v - NREQ : v;
  endfunction

  always_comb begin
    gnt   = '0;
    w_win = '0;
    w_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && req[wrap(int'(r_ptr) + k)]) begin
        w_any = 1'b1;
        w_win = IDW'(wrap(int'(r_ptr) + k));
      end
    end
    if (w_any) gnt[w_win] = 1'b1;
  end

  assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_id    <= '0;
    end else begin
      r_s1_valid <= w_any;
      if (w_any) begin
        r_ptr   <= w_ptr_nxt;
        r_s1_a  <= in1_flat[int'(w_win)*N +: N];
        r_s1_b  <= in2_flat[int'(w_win)*N +: N];
        r_s1_id <= w_win;
      end
    end
  end

  sat_add #(.N(N)) u_sat_add (
    .a   (r_s1_a),
    .b   (r_s1_b),
    .sum (w_sum),
    .sat (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out     <= w_sum;
        r_out_id  <= r_s1_id;
        r_out_sat <= w_sat;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign out_id    = r_out_id;
  assign out_sat   = r_out_sat;
endmodule

// File: doc/sat_add_arb.md
# sat_add_arb

Round-robin arbiter that shares one signed saturating adder between NREQ requesters. Each requester presents an operand pair with a request. The arbiter grants one requester per cycle and registers the winner's operands. One cycle later it returns the saturated sum, tagged with the requester id. The block sits in front of the saturating-adder datapath, so several producers can use a single adder instead of instantiating one each.

## Interface
- N, 8, operand/result width, two's complement, N ≥ 2
- NREQ, 4, number of requesters, 2..16
- IDW, $clog2(NREQ), id width (derived, not overridden)

Ports (clock and reset first):
- clk  in  1  rising-edge clock; the block has one clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request, level
- in1_flat  in  NREQ*N  operand A of requester i at bits [i*N +: N], signed
- in2_flat  in  NREQ*N  operand B of requester i at bits [i*N +: N], signed
- gnt  out  NREQ  one-hot grant, combinational from req and pointer
- out  out  N  registered saturated sum, signed
- out_valid  out  1  one-cycle pulse, out/out_id/out_sat valid
- out_id  out  IDW  index of requester owning out
- out_sat  out  1  sum was clamped

## Operation
- Arbitration:
  - Round-robin pointer ptr (IDW bits).
  - Search order is ptr, ptr+1, …, wrapping modulo NREQ.
  - gnt is the first requester in search order with req high; gnt is 0 when req is 0.
  - gnt is never asserted for a requester whose req is low.
- Accept: at a rising edge with gnt ≠ 0:
  - Stage 1 captures the granted requester's in1, in2, id and s1_valid=1.
  - ptr becomes winner+1, wrapping (NREQ-1 → 0).
  - With no grant, s1_valid=0 and ptr holds.
- Requester handshake:
  - Hold req and operands stable until an edge where its gnt bit is high.
  - The transfer completes on that edge.
  - Keeping req high afterwards issues a new request; back-to-back grants to one requester occur only when no other requester is pending.
  - Dropping req before being granted is legal; nothing is issued.
- Stage 2, at the next edge:
  - out = sat(a+b), out_id = s1 id, out_sat = clamp flag, out_valid = s1_valid.
  - out/out_id/out_sat hold their last value when out_valid=0.
- Saturation:
  - Raw sum is N+1 bits.
  - Overflow when a and b have the same sign and bit N-1 of the raw sum differs from it.
  - Positive overflow → 2^(N-1)-1; negative overflow → -2^(N-1); otherwise the sum truncated to N bits.
  - out_sat = 1 exactly when clamped.
  - Decision is purely from the operands; it never depends on prior out.
- No output backpressure: every accepted request produces exactly one out_valid pulse.
- Pipeline accepts one grant per cycle; sustained throughput is 1 result/cycle.

## Timing
- Reset (rst_n low, asynchronous): ptr=0, s1_valid=0, out=0, out_valid=0, out_id=0, out_sat=0.
- gnt stays combinational during reset (ptr=0 priority); no transfer occurs while rst_n is low.
- Reset mid-operation: in-flight stage-1/stage-2 contents are discarded and no out_valid is produced for them. Requesters must re-request after release.
- Release is synchronous to clk in the surrounding logic; the first accept can occur on the first edge with rst_n high.
- Latency: accepting edge E0 → out_valid high during the cycle after edge E1 (2 edges after the grant is sampled).
- ptr update and stage-1 capture occur on the same edge.
- All requesters high continuously: grants rotate 0,1,2,3,0,… starting from ptr.

## Structure
- Package sat_pkg:
  - default N and NREQ
  - function sat_max(N) = {0,1…1}, sat_min(N) = {1,0…0}
  - id-width helper
- Sub-module sat_add (combinational, parameter N):
  - ports a, b, sum, sat
  - instantiated once, between stage 1 and stage 2
- Arbiter priority search, ptr and pipeline registers live in sat_add_arb.

## Test plan
- Reset then single req[2] with 100+50 (N=8) → gnt=0100 same cycle; out=127, out_sat=1, out_id=2, out_valid after 2 edges.
- req[0] with -100+-50 → out=-128, out_sat=1. Then -128+-1 → -128, sat=1. Then 100+-50 → 50, sat=0. Then 127+0 → 127, sat=0.
- All four req held high for 8 cycles from ptr=0 → grant order 0,1,2,3,0,1,2,3; out_id sequence matches with 2-edge lag; 8 consecutive out_valid.
- req[1] and req[3] high, ptr=2 → 3 granted first, then 1; req[1] dropped before its grant → no result for id 1.
- rst_n pulsed low while two results are in flight → out_valid never asserts for them, ptr=0, outputs 0 immediately (asynchronously).
- Idle cycles (req=0) between requests → gnt=0, out_valid=0, out/out_id hold previous values, ptr unchanged.
